// File: rtl/dm_store_buffer.sv
// Store buffer between MEM and data memory: queues committed stores and drains them in order,
// giving loads priority on the DM port and stalling loads that hit a pending store.
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [3:0]    st_be,
    input  logic [31:0]   st_pc,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    input  logic          dm_ready,
    output logic          stall,
    output logic          dm_we,
    output logic          dm_re,
    output logic [31:0]   dm_addr,
    output logic [31:0]   dm_wd,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_pc,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          hit, load_serve, drain, enq;
    logic [PW-1:0] off;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // An entry is occupied when its distance from head is below count; word-granular match.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ((CW'(off) < count_q) && (addr_q[i][31:2] == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
        hit = hit && ld_valid;
    end

    assign load_serve = ld_valid && !hit && dm_ready;
    assign drain      = !empty && dm_ready && !(ld_valid && !hit);
    assign enq        = st_valid && !full && !ld_valid;
    assign stall      = (st_valid && full) || (ld_valid && (hit || !dm_ready));

    always_comb begin
        dm_we   = drain;
        dm_re   = load_serve;
        dm_addr = load_serve ? ld_addr : addr_q[head_q];
        dm_wd   = data_q[head_q];
        dm_be   = be_q[head_q];
        dm_pc   = pc_q[head_q];
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (enq) begin
            tail_d = tail_q + PW'(1);
        end
        unique case ({enq, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
                be_q[tail_q]   <= st_be;
                pc_q[tail_q]   <= st_pc;
            end
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: reset, drain order, wrap, load hit/miss and async reset.
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        dm_ready;
    logic        stall, dm_we, dm_re, empty, full;
    logic [31:0] dm_addr, dm_wd, dm_pc;
    logic [3:0]  dm_be;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    dm_store_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_be    (st_be),
        .st_pc    (st_pc),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .dm_ready (dm_ready),
        .stall    (stall),
        .dm_we    (dm_we),
        .dm_re    (dm_re),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_be    (dm_be),
        .dm_pc    (dm_pc),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    // Upstream must never present a load and a store together.
    always @(negedge clk) begin
        if (reset && st_valid && ld_valid) begin
            errors++;
            $error("protocol: st_valid and ld_valid both high");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        st_valid = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = 4'hF;
        st_pc    = pc;
        ld_valid = 1'b0;
    endtask

    initial begin
        // Reset with junk inputs
        reset    = 1'b0;
        st_valid = 1'b1;
        st_addr  = 32'hFFFF_FFFC;
        st_data  = 32'hA5A5_A5A5;
        st_be    = 4'h5;
        st_pc    = 32'h1234_5678;
        ld_valid = 1'b0;
        ld_addr  = 32'hFFFF_FFFC;
        dm_ready = 1'b1;
        repeat (2) tick();
        sample();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_we", 32'(dm_we), 32'd0);
        idle();
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_re", 32'(dm_re), 32'd0);
        tick();
        reset = 1'b1;

        // Single store, drained one cycle later
        store(32'h10, 32'hDEAD_BEEF, 32'h3000);
        sample();
        chk("ss_stall", 32'(stall), 32'd0);
        chk("ss_we0", 32'(dm_we), 32'd0);
        tick();
        idle();
        sample();
        chk("ss_we1", 32'(dm_we), 32'd1);
        chk("ss_addr", dm_addr, 32'h10);
        chk("ss_wd", dm_wd, 32'hDEAD_BEEF);
        chk("ss_be", 32'(dm_be), 32'hF);
        chk("ss_pc", dm_pc, 32'h3000);
        chk("ss_count1", 32'(count), 32'd1);
        tick();
        sample();
        chk("ss_empty", 32'(empty), 32'd1);
        chk("ss_we2", 32'(dm_we), 32'd0);
        tick();

        // Fill, stall on full, then drain with wrap
        dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'(i * 4), 32'hA0 + 32'(i), 32'h100 + 32'(i));
            tick();
        end
        store(32'h10, 32'hB0, 32'h200);
        sample();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_stall", 32'(stall), 32'd1);
        chk("fill_we", 32'(dm_we), 32'd0);
        tick();
        sample();
        chk("fill_stall_held", 32'(stall), 32'd1);
        chk("fill_count_held", 32'(count), 32'd4);
        dm_ready = 1'b1;
        #1;
        chk("drain0_we", 32'(dm_we), 32'd1);
        chk("drain0_addr", dm_addr, 32'h0);
        chk("drain0_wd", dm_wd, 32'hA0);
        chk("drain0_stall", 32'(stall), 32'd1);
        tick();
        sample();
        chk("drain1_stall", 32'(stall), 32'd0);
        chk("drain1_addr", dm_addr, 32'h4);
        chk("drain1_count", 32'(count), 32'd3);
        tick();
        idle();
        sample();
        chk("drain2_count", 32'(count), 32'd3);
        chk("drain2_addr", dm_addr, 32'h8);
        tick();
        sample();
        chk("drain3_addr", dm_addr, 32'hC);
        chk("drain3_pc", dm_pc, 32'h103);
        tick();
        sample();
        chk("drain4_addr", dm_addr, 32'h10);
        chk("drain4_wd", dm_wd, 32'hB0);
        chk("drain4_we", 32'(dm_we), 32'd1);
        tick();
        sample();
        chk("drain_empty", 32'(empty), 32'd1);
        tick();

        // Load that hits a pending store
        store(32'h20, 32'h1234_5678, 32'h3010);
        tick();
        idle();
        ld_valid = 1'b1;
        ld_addr  = 32'h20;
        sample();
        chk("hit_stall", 32'(stall), 32'd1);
        chk("hit_we", 32'(dm_we), 32'd1);
        chk("hit_addr", dm_addr, 32'h20);
        chk("hit_re", 32'(dm_re), 32'd0);
        tick();
        sample();
        chk("hit2_stall", 32'(stall), 32'd0);
        chk("hit2_re", 32'(dm_re), 32'd1);
        chk("hit2_addr", dm_addr, 32'h20);
        chk("hit2_count", 32'(count), 32'd0);
        chk("hit2_we", 32'(dm_we), 32'd0);
        tick();
        idle();

        // Load miss takes priority over drain
        store(32'h30, 32'h3333_3333, 32'h3020);
        tick();
        idle();
        ld_valid = 1'b1;
        ld_addr  = 32'h40;
        dm_ready = 1'b0;
        sample();
        chk("miss_nr_stall", 32'(stall), 32'd1);
        chk("miss_nr_re", 32'(dm_re), 32'd0);
        dm_ready = 1'b1;
        #1;
        chk("miss_re", 32'(dm_re), 32'd1);
        chk("miss_addr", dm_addr, 32'h40);
        chk("miss_we", 32'(dm_we), 32'd0);
        chk("miss_stall", 32'(stall), 32'd0);
        chk("miss_count", 32'(count), 32'd1);
        tick();
        idle();
        sample();
        chk("miss_count_after", 32'(count), 32'd1);
        chk("miss_drain_we", 32'(dm_we), 32'd1);
        chk("miss_drain_addr", dm_addr, 32'h30);
        tick();
        sample();
        chk("miss_empty", 32'(empty), 32'd1);
        tick();

        // Asynchronous reset with three pending stores
        dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store(32'h50 + 32'(i * 4), 32'hC0 + 32'(i), 32'h400 + 32'(i));
            tick();
        end
        idle();
        sample();
        chk("mr_count3", 32'(count), 32'd3);
        dm_ready = 1'b1;
        #1;
        chk("mr_we_pre", 32'(dm_we), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mr_count0", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_we", 32'(dm_we), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("mr_no_we", 32'(dm_we), 32'd0);
            tick();
        end
        chk("mr_count_end", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Write buffer between the MEM pipeline stage and the data memory. It queues committed stores (address, data, byte enables, PC) in a small FIFO and drains them to the DM write port in program order. Loads take priority on the DM port. A load that matches a pending store stalls until the buffer has drained past that store, so a load never returns stale data.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- CW, 3, count width; must be ≥ log2(DEPTH)+1

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset (0 = reset); clears all state immediately, without waiting for a clock edge
- st_valid  input  1  MEM stage presents a store this cycle
- st_addr  input  32  store byte address
- st_data  input  32  store data, already lane-aligned
- st_be  input  4  store byte enables
- st_pc  input  32  PC of the store, carried for DM trace display
- ld_valid  input  1  MEM stage presents a load this cycle
- ld_addr  input  32  load byte address
- dm_ready  input  1  DM port usable this cycle; tie to 1 when the DM has no wait states
- stall  output  1  freeze MEM and the earlier stages this cycle
- dm_we, dm_re  output  1  DM write / read strobe
- dm_addr  output  32  DM address
- dm_wd  output  32  DM write data
- dm_be  output  4  DM byte enables
- dm_pc  output  32  PC for the DM trace
- count  output  CW  occupied entries
- empty, full  output  1  count==0 / count==DEPTH

## Operation
- Circular FIFO with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- st_valid and ld_valid are mutually exclusive. If both are high, the load is served and the store is ignored; a bench assertion flags this case.
- hit = ld_valid && some occupied entry has addr[31:2] == ld_addr[31:2]. The byte enables are not considered.
- Load serve (ld_valid && !hit && dm_ready):
  - dm_re=1, dm_addr=ld_addr, dm_we=0.
  - No drain this cycle.
- Drain (!empty && dm_ready && !(ld_valid && !hit)):
  - dm_we=1, with dm_addr/dm_wd/dm_be/dm_pc taken from the head entry.
  - Head advances at the clock edge.
- Enqueue (st_valid && !full && !ld_valid): the entry is written at tail and tail advances at the clock edge.
- stall = (st_valid && full) || (ld_valid && (hit || !dm_ready)).
- Count update:
  - +1 on enqueue, −1 on drain.
  - Enqueue and drain in the same cycle leave count unchanged.
  - A store that arrives while full is not accepted in that cycle, even if a drain occurs in the same cycle.
- When neither a drain nor a load serve happens: dm_we=0, dm_re=0, dm_addr=head address (don't-care), dm_wd=head data.

## Timing
- Reset values: count=0, empty=1, full=0, head=tail=0, dm_we=0. With ld_valid and st_valid low, stall=0 and dm_re=0.
- A reset during operation discards all pending stores; no further dm_we is issued for them.
- All outputs are combinational from the registered FIFO state and the current inputs. The DM samples them on the same posedge at which head and count update.
- Store-to-DM latency: an enqueued store is visible to drain one cycle after acceptance, so the minimum latency is 1 cycle.
- A stalled store or load must be held stable by the upstream stage until stall falls.
- A load that hits drains at most one entry per cycle. The stall lasts until no matching entry remains; the load is served in the first cycle with no hit and dm_ready=1.

## Test plan
- Reset: hold reset=0, drive junk on the inputs → count=0, empty=1, dm_we=0; stall=0 when ld/st are low; the state clears asynchronously, with no clock edge required.
- Single store: st 0x10 / 0xDEADBEEF / be=F / pc=0x3000 at cycle 0, then idle → cycle 1: dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF, dm_pc=0x3000. Cycle 2: empty=1.
- Fill and wrap:
  - With dm_ready=0, stores to 0x0, 0x4, 0x8, 0xC → full=1, count=4.
  - A 5th store to 0x10 → stall=1, held.
  - Raise dm_ready → 0x0 drains; the next cycle accepts 0x10 (tail wraps to 0).
  - Subsequent drains occur in order 0x4, 0x8, 0xC, 0x10.
- Load hit: store 0x20 = 0x12345678, then load 0x20 next cycle →
  - Load cycle 1: stall=1, dm_we=1 to 0x20.
  - Load cycle 2: stall=0, dm_re=1, dm_addr=0x20, count=0.
- Load miss priority: buffer holds a store to 0x30; load 0x40 with dm_ready=1 → dm_re=1, dm_addr=0x40, dm_we=0, stall=0, count stays 1. The next idle cycle drains 0x30.
- Reset mid-operation: with count=3, pull reset low between clock edges → count=0 and empty=1 immediately; after release, no dm_we occurs for the discarded entries.
